pacman_mem_arbiter: RTL and testbench
=====================================

Name: pacman_mem_arbiter

Overview:
- Shares the single-port Pac-Man sprite/state RAM between two requesters: the ARM CPU (memory-mapped port, read/write) and the VGA pixel fetcher (read-only, burst).
- The CPU has fixed priority. A starvation counter forces a VGA burst once VGA has waited MAX_WAIT cycles.
- During a forced VGA burst the CPU is stalled.
- Sits between the address-decoder chip select for the Pac-Man region and the RAM, replacing direct CPU wiring.

Parameters:
- DEPTH, 512, RAM words; address width AW = clog2(DEPTH).
- MAX_WAIT, 8, cycles VGA may wait before it preempts the CPU (range 1..255).
- BURST, 4, maximum consecutive VGA grants per preemption (range 1..16).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- cpu_sel  in  1  CPU access request (decoder chip select for the Pac-Man region)
- cpu_wr_n  in  1  CPU write strobe, active-low (1 = read)
- cpu_addr  in  AW  CPU word address, already offset into the region
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data, valid when cpu_rvalid=1
- cpu_rvalid  out  1  pulses one cycle after a granted CPU read
- cpu_stall  out  1  CPU request not served this cycle; hold inputs
- vga_req  in  1  VGA read request; held until granted
- vga_addr  in  AW  VGA word address
- vga_gnt  out  1  VGA request accepted this cycle
- vga_rdata  out  32  VGA read data
- vga_rvalid  out  1  pulses one cycle after vga_gnt
- mem_addr  out  AW  RAM address
- mem_wdata  out  32  RAM write data
- mem_wr_n  out  1  RAM write strobe, active-low
- mem_rdata  in  32  RAM read data, one-cycle registered latency

Behaviour:
- Reset (rst=0, async): FSM=CPU_PRI; wait_cnt=0; burst_cnt=0. Outputs: cpu_stall=0, vga_gnt=0, cpu_rvalid=0, vga_rvalid=0, mem_wr_n=1, mem_addr=0, mem_wdata=0, cpu_rdata=0, vga_rdata=0.
- Grant decision is combinational within the cycle. mem_* are driven from the winner's inputs. The idle cycle drives mem_wr_n=1 and mem_addr=0.
- States:
  - CPU_PRI:
    - If cpu_sel: grant CPU. If also vga_req, wait_cnt++.
    - Else if vga_req: grant VGA (vga_gnt=1) and clear wait_cnt.
    - When wait_cnt reaches MAX_WAIT with vga_req still high: go to VGA_BURST next cycle and load burst_cnt=BURST.
  - VGA_BURST:
    - If vga_req: grant VGA and decrement burst_cnt. If cpu_sel, assert cpu_stall=1 and ignore the CPU access (no write).
    - Exit to CPU_PRI when burst_cnt reaches 0 after a grant, or when vga_req drops. Clear wait_cnt on exit.
- The CPU is never stalled in CPU_PRI. The stall is combinational and has zero latency from the state.
- Read return:
  - *_rvalid is registered and asserted exactly one cycle after the grant of a read.
  - *_rdata captures mem_rdata on that cycle and holds its value until the next rvalid.
- CPU writes produce no cpu_rvalid.
- The stalled CPU access is retried by the CPU holding its inputs. When it is finally granted, it executes exactly once.
- wait_cnt saturates at MAX_WAIT and never wraps. burst_cnt never underflows.
- A vga_req deassert mid-burst ends the burst immediately, with no dead cycle.
- Simultaneous cpu_sel and vga_req in CPU_PRI with wait_cnt<MAX_WAIT: the CPU wins.
- Reset mid-burst: the FSM returns to CPU_PRI and any pending rvalid is dropped. Reset asserted in the cycle after a read grant: no rvalid is produced.

Decomposition:
- Package pacman_mem_pkg: typedef enum logic {CPU_PRI, VGA_BURST} arb_state_t; region base constant PACMAN_BASE = 513; default DEPTH.
- Sub-module sat_counter (load, decrement or increment, saturate), instantiated for wait_cnt and burst_cnt.

Test Plan:
- Reset: drive rst=0 with random inputs. All outputs must hold their reset values, mem_wr_n=1. Release rst: first grant follows one clock later.
- CPU-only: write 0xDEADBEEF to addr 5, then read addr 5. Expect mem_wr_n=0 for exactly 1 cycle, then cpu_rvalid=1 one cycle after the read with cpu_rdata=0xDEADBEEF, and cpu_stall=0 throughout.
- VGA-only: vga_req held for 6 cycles, addresses 0..5. Expect vga_gnt=1 every cycle and vga_rvalid on cycles 2..7 with the matching data.
- Starvation: cpu_sel and vga_req continuously high, MAX_WAIT=8, BURST=4. Expect 8 CPU grants, then 4 VGA grants with cpu_stall=1, then CPU grants resume, and the pattern repeats.
- Early burst end: as in the starvation test, but drop vga_req after 2 burst grants. Expect the CPU granted on the next cycle, cpu_stall=0, and the stalled CPU write performed exactly once.
- Reset mid-burst: assert rst in burst cycle 2. Expect an immediate return to idle outputs, no vga_rvalid, and CPU_PRI after release.

Source files
------------

// File: rtl/pacman_mem_pkg.sv
// ============================================================================
// Module : pacman_mem_pkg
// Brief  : Shared types and constants for the Pac-Man RAM arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pacman_mem_pkg;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        VGA_BURST = 1'b1
    } arb_state_t;

    localparam int PACMAN_BASE      = 513;
    localparam int DEFAULT_DEPTH    = 512;
    localparam int DEFAULT_MAX_WAIT = 8;
    localparam int DEFAULT_BURST    = 4;
    localparam int DATA_W           = 32;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Loadable up/down counter that saturates at MAX and never drops below 0.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_cnt_next
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next;

    // Clear beats load beats count; inc and dec together cancel out.
    always_comb begin
        w_next = r_cnt;
        if (i_clr) begin
            w_next = '0;
        end else if (i_load) begin
            w_next = (i_load_val > C_MAX) ? C_MAX : i_load_val;
        end else if (i_inc && !i_dec) begin
            w_next = (r_cnt >= C_MAX) ? C_MAX : r_cnt + WIDTH'(1);
        end else if (i_dec && !i_inc) begin
            w_next = (r_cnt == '0) ? '0 : r_cnt - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = w_next;

endmodule

`default_nettype wire

// File: rtl/pacman_mem_arbiter.sv
// ============================================================================
// Module : pacman_mem_arbiter
// Brief  : Single-port RAM arbiter, CPU fixed priority with VGA anti-starvation bursts.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pacman_mem_arbiter
    import pacman_mem_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int BURST    = DEFAULT_BURST,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cpu_sel,
    input  logic              i_cpu_wr_n,
    input  logic [AW-1:0]     i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_rvalid,
    output logic              o_cpu_stall,
    input  logic              i_vga_req,
    input  logic [AW-1:0]     i_vga_addr,
    output logic              o_vga_gnt,
    output logic [DATA_W-1:0] o_vga_rdata,
    output logic              o_vga_rvalid,
    output logic [AW-1:0]     o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_wr_n,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int WW = cnt_width(MAX_WAIT);
    localparam int BW = cnt_width(BURST);
    localparam logic [WW-1:0] C_MAX_WAIT = WW'(MAX_WAIT);
    localparam logic [BW-1:0] C_BURST    = BW'(BURST);

    arb_state_t        r_state;
    logic              r_active;
    logic              r_cpu_rvalid;
    logic              r_vga_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_vga_rdata;

    logic              w_in_burst;
    logic              w_vga_gnt;
    logic              w_cpu_gnt;
    logic              w_stall;
    logic              w_exit;
    logic              w_wait_inc;
    logic              w_wait_clr;
    logic              w_wait_hit;
    logic              w_burst_dec;
    logic [WW-1:0]     w_wait_cnt;
    logic [WW-1:0]     w_wait_next;
    logic [BW-1:0]     w_burst_cnt;
    logic [BW-1:0]     w_burst_next;

    // r_active holds off every grant until the first clock after reset release.
    assign w_in_burst  = (r_state == VGA_BURST);
    assign w_vga_gnt   = r_active && i_vga_req && (w_in_burst || !i_cpu_sel);
    assign w_cpu_gnt   = r_active && i_cpu_sel && !w_vga_gnt;
    assign w_stall     = w_in_burst && i_cpu_sel && i_vga_req;

    assign w_wait_inc  = !w_in_burst && w_cpu_gnt && i_vga_req && (w_wait_cnt != C_MAX_WAIT);
    assign w_wait_hit  = w_wait_inc && (w_wait_next == C_MAX_WAIT);
    assign w_burst_dec = w_in_burst && w_vga_gnt && (w_burst_cnt != '0);
    assign w_exit      = w_in_burst && (!i_vga_req || (w_burst_next == '0));
    assign w_wait_clr  = (!w_in_burst && w_vga_gnt) || w_exit;

    sat_counter #(
        .WIDTH (WW),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_wait_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_wait_inc),
        .i_dec      (1'b0),
        .o_cnt      (w_wait_cnt),
        .o_cnt_next (w_wait_next)
    );

    // An early vga_req drop leaves credits behind; clear them so they never leak.
    sat_counter #(
        .WIDTH (BW),
        .MAX   (BURST)
    ) u_burst_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_exit && !i_vga_req),
        .i_load     (w_wait_hit),
        .i_load_val (C_BURST),
        .i_inc      (1'b0),
        .i_dec      (w_burst_dec),
        .o_cnt      (w_burst_cnt),
        .o_cnt_next (w_burst_next)
    );

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wr_n  = 1'b1;
        if (w_vga_gnt) begin
            o_mem_addr = i_vga_addr;
        end else if (w_cpu_gnt) begin
            o_mem_addr  = i_cpu_addr;
            o_mem_wdata = i_cpu_wdata;
            o_mem_wr_n  = i_cpu_wr_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= CPU_PRI;
            r_active     <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_vga_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_vga_rdata  <= '0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                CPU_PRI:   if (w_wait_hit) r_state <= VGA_BURST;
                VGA_BURST: if (w_exit)     r_state <= CPU_PRI;
                default:                   r_state <= CPU_PRI;
            endcase
            r_cpu_rvalid <= w_cpu_gnt && i_cpu_wr_n;
            r_vga_rvalid <= w_vga_gnt;
            if (r_cpu_rvalid) r_cpu_rdata <= i_mem_rdata;
            if (r_vga_rvalid) r_vga_rdata <= i_mem_rdata;
        end
    end

    // RAM data arrives in the rvalid cycle; pass it through then, hold it after.
    assign o_cpu_rdata  = r_cpu_rvalid ? i_mem_rdata : r_cpu_rdata;
    assign o_vga_rdata  = r_vga_rvalid ? i_mem_rdata : r_vga_rdata;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_vga_rvalid = r_vga_rvalid;
    assign o_vga_gnt    = w_vga_gnt;
    assign o_cpu_stall  = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_pacman_mem_arbiter.sv
// ============================================================================
// Module : tb_pacman_mem_arbiter
// Brief  : Self-checking bench: directed scenarios plus randomized traffic vs a reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pacman_mem_arbiter;

    localparam int DEPTH    = 512;
    localparam int MAX_WAIT = 8;
    localparam int BURST    = 4;
    localparam int AW       = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_sel, cpu_wr_n, vga_req;
    logic [AW-1:0] cpu_addr, vga_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata, vga_rdata;
    logic          cpu_rvalid, cpu_stall, vga_gnt, vga_rvalid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_wr_n;

    always #5 clk = ~clk;

    pacman_mem_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT),
        .BURST    (BURST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cpu_sel    (cpu_sel),
        .i_cpu_wr_n   (cpu_wr_n),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_rvalid (cpu_rvalid),
        .o_cpu_stall  (cpu_stall),
        .i_vga_req    (vga_req),
        .i_vga_addr   (vga_addr),
        .o_vga_gnt    (vga_gnt),
        .o_vga_rdata  (vga_rdata),
        .o_vga_rvalid (vga_rvalid),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wr_n   (mem_wr_n),
        .i_mem_rdata  (mem_rdata)
    );

    // Synchronous RAM with one-cycle registered read.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (!mem_wr_n) ram[mem_addr] <= mem_wdata;
    end

    function automatic logic [31:0] init_word(input int a);
        return 32'hC0DE0000 + 32'(a);
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-transaction view of the arbitration rules.
    int          m_wait, m_burst_left;
    bit          m_active, m_pend_cpu, m_pend_vga;
    logic [31:0] m_cpu_pdata, m_vga_pdata, m_cpu_hold, m_vga_hold;
    logic [31:0] m_mem [DEPTH];
    bit          last_gnt, last_stall;

    task automatic model_step();
        bit            vga_turn, cpu_turn, stall;
        logic [AW-1:0] e_addr;
        if (!rst_n) begin
            chk("rst_cpu_stall", cpu_stall, 0);
            chk("rst_vga_gnt", vga_gnt, 0);
            chk("rst_cpu_rvalid", cpu_rvalid, 0);
            chk("rst_vga_rvalid", vga_rvalid, 0);
            chk("rst_mem_wr_n", mem_wr_n, 1);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
            chk("rst_vga_rdata", vga_rdata, 0);
            m_wait = 0; m_burst_left = 0; m_active = 0;
            m_pend_cpu = 0; m_pend_vga = 0;
            m_cpu_hold = 0; m_vga_hold = 0;
            last_gnt = 0; last_stall = 0;
            return;
        end
        chk("cpu_rvalid", cpu_rvalid, m_pend_cpu);
        chk("vga_rvalid", vga_rvalid, m_pend_vga);
        chk("cpu_rdata", cpu_rdata, m_pend_cpu ? m_cpu_pdata : m_cpu_hold);
        chk("vga_rdata", vga_rdata, m_pend_vga ? m_vga_pdata : m_vga_hold);

        vga_turn = m_active && vga_req && (m_burst_left > 0 || !cpu_sel);
        cpu_turn = m_active && cpu_sel && !vga_turn;
        stall    = cpu_sel && vga_req && (m_burst_left > 0);
        e_addr   = vga_turn ? vga_addr : (cpu_turn ? cpu_addr : '0);
        chk("vga_gnt", vga_gnt, vga_turn);
        chk("cpu_stall", cpu_stall, stall);
        chk("mem_wr_n", mem_wr_n, cpu_turn ? cpu_wr_n : 1'b1);
        chk("mem_addr", mem_addr, e_addr);
        if (cpu_turn && !cpu_wr_n) chk("mem_wdata", mem_wdata, cpu_wdata);

        if (m_pend_cpu) m_cpu_hold = m_cpu_pdata;
        if (m_pend_vga) m_vga_hold = m_vga_pdata;
        m_pend_cpu  = cpu_turn && cpu_wr_n;
        m_cpu_pdata = m_mem[cpu_addr];
        m_pend_vga  = vga_turn;
        m_vga_pdata = m_mem[vga_addr];
        if (cpu_turn && !cpu_wr_n) m_mem[cpu_addr] = cpu_wdata;

        if (m_burst_left > 0) begin
            if (vga_req) m_burst_left--;
            else         m_burst_left = 0;
            if (m_burst_left == 0) m_wait = 0;
        end else if (cpu_turn && vga_req) begin
            if (m_wait < MAX_WAIT) m_wait++;
            if (m_wait == MAX_WAIT) m_burst_left = BURST;
        end else if (vga_turn) begin
            m_wait = 0;
        end
        m_active   = 1;
        last_gnt   = vga_turn;
        last_stall = stall;
    endtask

    always @(negedge clk) begin
        #2;
        model_step();
    end

    task automatic cyc(input bit s, input bit wn, input logic [AW-1:0] a, input logic [31:0] d,
                       input bit v, input logic [AW-1:0] va);
        @(negedge clk);
        cpu_sel = s; cpu_wr_n = wn; cpu_addr = a; cpu_wdata = d;
        vga_req = v; vga_addr = va;
    endtask

    task automatic idle();
        cyc(0, 1, '0, '0, 0, '0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            cpu_sel = 1'($urandom); cpu_wr_n = 1'($urandom); cpu_addr = AW'($urandom);
            cpu_wdata = $urandom; vga_req = 1'($urandom); vga_addr = AW'($urandom);
            if (i != 0) @(negedge clk);
            #3;
            chk("rst_hold_vga_gnt", vga_gnt, 0);
            chk("rst_hold_mem_wr_n", mem_wr_n, 1);
        end
        idle();
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]   = init_word(i);
            m_mem[i] = init_word(i);
        end
        rst_n = 1'b0;
        cpu_sel = 0; cpu_wr_n = 1; cpu_addr = '0; cpu_wdata = '0;
        vga_req = 0; vga_addr = '0;

        // Reset with random inputs, then first grant one clock after release.
        do_reset(4);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; vga_req = 1; vga_addr = 9'd3;
        #3 chk("release_no_gnt", vga_gnt, 0);
        cyc(0, 1, '0, '0, 1, 9'd3);
        #3 chk("release_first_gnt", vga_gnt, 1);
        idle();
        #3 chk("release_vga_rvalid", vga_rvalid, 1);
        chk("release_vga_rdata", vga_rdata, 32'hC0DE0003);

        // VGA only: six back-to-back grants, data one cycle behind.
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, '0, '0, i < 6, AW'(i));
            #3;
            chk("vga_only_gnt", vga_gnt, i < 6);
            if (i >= 1) begin
                chk("vga_only_rvalid", vga_rvalid, 1);
                chk("vga_only_rdata", vga_rdata, init_word(i - 1));
            end
        end
        idle();
        #3 chk("vga_only_rvalid_end", vga_rvalid, 0);

        // CPU only: write then read back.
        cyc(1, 0, 9'd5, 32'hDEADBEEF, 0, '0);
        #3 chk("cpu_wr_strobe", mem_wr_n, 0);
        chk("cpu_wr_stall", cpu_stall, 0);
        cyc(1, 1, 9'd5, '0, 0, '0);
        #3 chk("cpu_rd_strobe", mem_wr_n, 1);
        chk("cpu_wr_no_rvalid", cpu_rvalid, 0);
        idle();
        #3 chk("cpu_rd_rvalid", cpu_rvalid, 1);
        chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        idle();
        #3 chk("cpu_rd_rvalid_end", cpu_rvalid, 0);
        chk("cpu_rd_data_hold", cpu_rdata, 32'hDEADBEEF);

        // Starvation: 8 CPU grants, 4 forced VGA grants, repeating.
        do_reset(1);
        for (int i = 0; i < 24; i++) begin
            cyc(1, 1, AW'(i), '0, 1, AW'(100 + i));
            #3;
            chk("starve_vga_gnt", vga_gnt, (i % 12) >= 8);
            chk("starve_stall", cpu_stall, (i % 12) >= 8);
        end
        idle();

        // Early burst end: stalled write lands exactly once, no dead cycle.
        do_reset(1);
        for (int i = 0; i < 8; i++) cyc(1, 1, AW'(i), '0, 1, AW'(40 + i));
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 9'd9, 32'hCAFEF00D, 1, AW'(60 + i));
            #3 chk("early_burst_gnt", vga_gnt, 1);
            chk("early_burst_stall", cpu_stall, 1);
            chk("early_burst_no_wr", mem_wr_n, 1);
        end
        cyc(1, 0, 9'd9, 32'hCAFEF00D, 0, '0);
        #3 chk("early_end_stall", cpu_stall, 0);
        chk("early_end_vga_gnt", vga_gnt, 0);
        chk("early_end_wr", mem_wr_n, 0);
        chk("early_end_addr", mem_addr, 9);
        cyc(1, 1, 9'd9, '0, 0, '0);
        #3 chk("early_end_no_rewrite", mem_wr_n, 1);
        idle();
        #3 chk("early_end_rdata", cpu_rdata, 32'hCAFEF00D);

        // Reset in the cycle after a CPU read grant drops the rvalid.
        cyc(1, 1, 9'd1, '0, 0, '0);
        @(negedge clk); rst_n = 1'b0;
        cpu_sel = 0;
        #3 chk("rst_after_rd_rvalid", cpu_rvalid, 0);
        @(negedge clk); rst_n = 1'b1;
        idle();

        // Reset mid-burst.
        for (int i = 0; i < 8; i++) cyc(1, 1, 9'd7, '0, 1, AW'(20 + i));
        cyc(1, 1, 9'd7, '0, 1, 9'd28);
        #3 chk("midburst_gnt", vga_gnt, 1);
        @(negedge clk); rst_n = 1'b0;
        #3 chk("midburst_rst_gnt", vga_gnt, 0);
        chk("midburst_rst_rvalid", vga_rvalid, 0);
        chk("midburst_rst_addr", mem_addr, 0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        #3 chk("midburst_rel_idle", mem_addr, 0);
        cyc(1, 1, 9'd7, '0, 1, 9'd29);
        #3 chk("midburst_cpu_pri_gnt", vga_gnt, 0);
        chk("midburst_cpu_pri_stall", cpu_stall, 0);
        chk("midburst_cpu_pri_addr", mem_addr, 7);
        idle();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            int pc;
            pc = (k < 1500) ? 60 : 95;
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            if (!last_stall) begin
                cpu_sel   = ($urandom_range(0, 99) < pc);
                cpu_wr_n  = 1'($urandom);
                cpu_addr  = AW'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (!(vga_req && !last_gnt)) begin
                vga_req  = ($urandom_range(0, 99) < 50);
                vga_addr = AW'($urandom_range(0, 15));
            end
        end
        @(negedge clk); rst_n = 1'b1;
        idle();
        idle();
        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
